// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM peripheral.
package pwm_pkg;

  localparam int NUM_CH_MAX = 32;

  // Byte-bus register map
  localparam logic [6:0] ADDR_OUT_EN0   = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN0   = 7'h04;
  localparam logic [6:0] ADDR_PRESCALE  = 7'h08;
  localparam logic [6:0] ADDR_MODE      = 7'h09;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_e;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler plus the shared up or up/down period counter.
// boundary marks the tick that begins a new PWM period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prescale,
  input  mode_e            mode,
  input  logic             clr_pcnt,
  input  logic             clr_all,
  output logic             boundary,
  output logic [WIDTH-1:0] cnt,
  output logic             dir
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] TOP_UP  = MAX - 1'b1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [7:0] pcnt;
  logic       tick;

  assign tick     = (pcnt == prescale);
  assign boundary = tick && (cnt == '0) && !dir;

  // Prescaler: counts 0..prescale and restarts; any prescale or mode write restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr_pcnt || clr_all || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // Period counter: sawtooth in edge mode, triangle (dir=1 while falling) in centre mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (clr_all) begin
      cnt <= '0;
      dir <= 1'b0;
    end else if (tick) begin
      if (mode == MODE_EDGE) begin
        dir <= 1'b0;
        cnt <= (cnt == TOP_UP) ? '0 : cnt + 1'b1;
      end else if (!dir) begin
        if (cnt == TOP_UP) begin
          cnt <= MAX;
          dir <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == CNT_ONE) begin
          cnt <= '0;
          dir <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM peripheral: byte-bus register file, double-buffered
// per-channel duty, compare against a shared timebase, registered pin outputs.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [6:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic [NUM_CH-1:0]     out_en;
  logic [NUM_CH-1:0]     pwm_en;
  logic [7:0]            prescale;
  mode_e                 mode;
  logic [WIDTH-1:0]      duty   [NUM_CH];
  logic [WIDTH-1:0]      shadow [NUM_CH];

  logic [6:0]            wr_idx;
  logic [6:0]            rd_idx;
  logic                  wr_prescale;
  logic                  wr_mode;

  logic                  boundary;
  logic                  dir;
  logic [WIDTH-1:0]      cnt;

  logic [NUM_CH-1:0]     pwm_raw_p0;
  logic [NUM_CH-1:0]     out_p1;
  logic                  period_start_p1;
  logic [NUM_CH_MAX-1:0] out_en_w;
  logic [NUM_CH_MAX-1:0] pwm_en_w;

  // Out-of-range duty addresses wrap to large indices and never match a channel.
  assign wr_idx      = wr_addr - ADDR_DUTY_BASE;
  assign rd_idx      = rd_addr - ADDR_DUTY_BASE;
  assign wr_prescale = wr_en && (wr_addr == ADDR_PRESCALE);
  assign wr_mode     = wr_en && (wr_addr == ADDR_MODE);

  pwm_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale),
    .mode     (mode),
    .clr_pcnt (wr_prescale),
    .clr_all  (wr_mode),
    .boundary (boundary),
    .cnt      (cnt),
    .dir      (dir)
  );

  // Register file: byte-addressed writes, enable bits only exist for real channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en   <= '0;
      pwm_en   <= '0;
      prescale <= '0;
      mode     <= MODE_EDGE;
      for (int ch = 0; ch < NUM_CH; ch++) duty[ch] <= '0;
    end else if (wr_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_addr == (ADDR_OUT_EN0 | {5'b0, ch[4:3]})) out_en[ch] <= wr_data[ch[2:0]];
        if (wr_addr == (ADDR_PWM_EN0 | {5'b0, ch[4:3]})) pwm_en[ch] <= wr_data[ch[2:0]];
        if (wr_idx == ch[6:0]) duty[ch] <= wr_data[WIDTH-1:0];
      end
      if (wr_addr == ADDR_PRESCALE) prescale <= wr_data;
      if (wr_addr == ADDR_MODE) mode <= mode_e'(wr_data[0]);
    end
  end

  // Shadow duties reload only at the period boundary; a same-edge duty write is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) shadow[ch] <= '0;
    end else if (boundary) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow[ch] <= (wr_en && (wr_idx == ch[6:0])) ? wr_data[WIDTH-1:0] : duty[ch];
      end
    end
  end

  // ---- stage p0: compare ----
  // While falling the comparison includes equality so the pulse is exactly
  // 2*duty ticks wide, centred on the wrap, and full-scale duty never drops.
  always_comb begin
    pwm_raw_p0 = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pwm_raw_p0[ch] = dir ? (cnt <= shadow[ch]) : (cnt < shadow[ch]);
    end
  end

  // ---- stage p1: registered pin outputs and period pulse ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1          <= '0;
      period_start_p1 <= 1'b0;
    end else begin
      out_p1          <= out_en & (pwm_raw_p0 | ~pwm_en);
      period_start_p1 <= boundary;
    end
  end

  assign out          = out_p1;
  assign period_start = period_start_p1;

  // Readback mux: enable words padded to 32 bits, unmapped addresses read 0.
  always_comb begin
    out_en_w = '0;
    pwm_en_w = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      out_en_w[ch] = out_en[ch];
      pwm_en_w[ch] = pwm_en[ch];
    end
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_OUT_EN0:         rd_data = out_en_w[7:0];
      ADDR_OUT_EN0 + 7'd1:  rd_data = out_en_w[15:8];
      ADDR_OUT_EN0 + 7'd2:  rd_data = out_en_w[23:16];
      ADDR_OUT_EN0 + 7'd3:  rd_data = out_en_w[31:24];
      ADDR_PWM_EN0:         rd_data = pwm_en_w[7:0];
      ADDR_PWM_EN0 + 7'd1:  rd_data = pwm_en_w[15:8];
      ADDR_PWM_EN0 + 7'd2:  rd_data = pwm_en_w[23:16];
      ADDR_PWM_EN0 + 7'd3:  rd_data = pwm_en_w[31:24];
      ADDR_PRESCALE:        rd_data = prescale;
      ADDR_MODE:            rd_data = {7'b0, mode};
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (rd_idx == ch[6:0]) rd_data = 8'(duty[ch]);
        end
      end
    endcase
  end

endmodule
